// File: rtl/wb_arbiter2_pkg.sv
// wb_arbiter2_pkg: shared state encodings and grant codes for the two-master arbiter
package wb_arbiter2_pkg;
  typedef enum logic {ArbIdle = 1'b0, ArbBusy = 1'b1} arb_state_e;
  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntM0 = 2'b01;
  localparam logic [1:0] GntM1 = 2'b10;
endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// wb_watchdog: counts unacknowledged strobe cycles and flags expiry at the limit
module wb_watchdog (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wait_i,
  input  logic [7:0] limit,
  output logic       expire
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    expire = wait_i && (cnt_q == limit);
    cnt_d = (clr || expire) ? 8'd0 : wait_i ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone arbiter with a strobe watchdog
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);
  arb_state_e state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic busy, own_cyc, own_stb, expire, sel0, sel1;
  always_comb begin
    busy = (state_q == ArbBusy);
    own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
    sel0 = busy && !owner_q;
    sel1 = busy && owner_q;
    s_cyc_o = busy && own_cyc;
    s_stb_o = busy && own_stb && !expire;
    s_we_o = busy && (owner_q ? m1_we_i : m0_we_i);
    s_adr_o = !busy ? 32'd0 : owner_q ? m1_adr_i : m0_adr_i;
    s_dat_o = !busy ? 32'd0 : owner_q ? m1_dat_i : m0_dat_i;
    s_sel_o = !busy ? 4'd0 : owner_q ? m1_sel_i : m0_sel_i;
    m0_ack_o = sel0 && s_ack_i;
    m1_ack_o = sel1 && s_ack_i;
    m0_err_o = sel0 && expire;
    m1_err_o = sel1 && expire;
    m0_dat_o = sel0 ? s_dat_i : 32'd0;
    m1_dat_o = sel1 ? s_dat_i : 32'd0;
    gnt_o = sel0 ? GntM0 : sel1 ? GntM1 : GntNone;
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    // Contention goes to the master that was not granted last
    if (!busy && (m0_cyc_i || m1_cyc_i)) begin
      state_d = ArbBusy;
      owner_d = (m0_cyc_i && m1_cyc_i) ? !last_q : m1_cyc_i;
      last_d = owner_d;
    end else if (busy && !own_cyc) begin
      state_d = ArbIdle;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ArbIdle;
      owner_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
    end
  end
  wb_watchdog u_wd (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (!busy || s_ack_i),
    .wait_i(busy && own_stb && !s_ack_i),
    .limit (8'(TIMEOUT - 1)),
    .expire(expire)
  );
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed checks of grant, alternation, locking, timeout and reset
module tb_wb_arbiter2;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0, m1_adr = 0, m1_dat = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0] s_sel_o;
  logic [1:0] gnt_o;
  logic ack_en = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // Zero-wait slave: switch register at 0xF020 reads 0xA5
  assign s_ack_i = ack_en && s_cyc_o;
  assign s_dat_i = (s_adr_o == 32'h0000_F020) ? 32'h0000_00A5 : 32'h0;

  wb_arbiter2 #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    nxt;
    nxt;
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("rst_sstb", 32'(s_stb_o), 32'h0);
    chk("rst_m0ack", 32'(m0_ack_o), 32'h0);
    chk("rst_m1err", 32'(m1_err_o), 32'h0);
    // Contention straight after reset
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'hF010; m0_dat = 32'h1234; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hF020;
    ack_en = 1;
    #1;
    chk("lat_scyc_idle", 32'(s_cyc_o), 32'h0);
    nxt;
    chk("c1_gnt", 32'(gnt_o), 32'h1);
    chk("c1_scyc", 32'(s_cyc_o), 32'h1);
    chk("c1_m0ack", 32'(m0_ack_o), 32'h1);
    chk("c1_m1ack", 32'(m1_ack_o), 32'h0);
    chk("c1_m1dat", m1_dat_o, 32'h0);
    chk("c1_sadr", s_adr_o, 32'hF010);
    chk("c1_sdat", s_dat_o, 32'h1234);
    chk("c1_swe", 32'(s_we_o), 32'h1);
    chk("c1_ssel", 32'(s_sel_o), 32'hF);
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    nxt;
    chk("arb_idle_gnt", 32'(gnt_o), 32'h0);
    chk("arb_idle_scyc", 32'(s_cyc_o), 32'h0);
    chk("arb_idle_m1ack", 32'(m1_ack_o), 32'h0);
    nxt;
    // M1 locked read sequence; M0 requests meanwhile
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_gnt", 32'(gnt_o), 32'h2);
      chk("lock_m1ack", 32'(m1_ack_o), 32'h1);
      chk("lock_m1dat", m1_dat_o, 32'hA5);
      chk("lock_m0ack", 32'(m0_ack_o), 32'h0);
      chk("lock_m0dat", m0_dat_o, 32'h0);
      chk("lock_sadr", s_adr_o, 32'hF020);
      if (i < 2) nxt;
    end
    m1_cyc = 0; m1_stb = 0;
    nxt;
    chk("rel_gnt", 32'(gnt_o), 32'h0);
    chk("rel_m0ack", 32'(m0_ack_o), 32'h0);
    m1_cyc = 1; m1_stb = 1;
    nxt;
    chk("alt_gnt", 32'(gnt_o), 32'h1);
    chk("alt_m0ack", 32'(m0_ack_o), 32'h1);
    chk("alt_m0dat", m0_dat_o, 32'h0);
    chk("alt_m1ack", 32'(m1_ack_o), 32'h0);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; ack_en = 0;
    nxt;
    chk("end_idle_gnt", 32'(gnt_o), 32'h0);
    // Watchdog with TIMEOUT=4 and a slave that never acks
    m0_cyc = 1; m0_stb = 1;
    nxt;
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 4; c++) begin
        chk("wd_err", 32'(m0_err_o), 32'(c == 4));
        chk("wd_sstb", 32'(s_stb_o), 32'(c != 4));
        chk("wd_ack", 32'(m0_ack_o), 32'h0);
        chk("wd_m1err", 32'(m1_err_o), 32'h0);
        nxt;
      end
    end
    m0_cyc = 0; m0_stb = 0;
    nxt;
    chk("wd_idle_gnt", 32'(gnt_o), 32'h0);
    // Reset while M1 is mid-strobe
    m1_cyc = 1; m1_stb = 1;
    nxt;
    chk("mr_gnt", 32'(gnt_o), 32'h2);
    chk("mr_sstb", 32'(s_stb_o), 32'h1);
    rst = 1;
    nxt;
    chk("mr_rst_gnt", 32'(gnt_o), 32'h0);
    chk("mr_rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("mr_rst_sstb", 32'(s_stb_o), 32'h0);
    chk("mr_rst_sadr", s_adr_o, 32'h0);
    chk("mr_rst_m1ack", 32'(m1_ack_o), 32'h0);
    chk("mr_rst_m1err", 32'(m1_err_o), 32'h0);
    rst = 0;
    m0_cyc = 1; m0_stb = 1;
    nxt;
    chk("post_rst_gnt", 32'(gnt_o), 32'h1);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
